// File: rtl/neuraedge_tile_pkg.sv
// Shared types and default sizes for the neuraedge tile operand/accumulator path.
package neuraedge_tile_pkg;

  localparam int unsigned FE_DATA_W      = 8;
  localparam int unsigned FE_ACC_W       = 32;
  localparam int unsigned FE_K_W         = 12;
  localparam int unsigned FE_TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    FE_IDLE     = 3'd0,
    FE_CLEAR    = 3'd1,
    FE_STREAM   = 3'd2,
    FE_WAIT_ACC = 3'd3,
    FE_RESULT   = 3'd4
  } fe_state_t;

endpackage

// File: rtl/neuraedge_pe_feeder.sv
// Sequences one dot-product of cfg_k_len MACs into a PE and returns its accumulator on a result stream.
// Optional WAIT_ACC watchdog with res_err output: define NEURAEDGE_FEEDER_TIMEOUT_EN.
module neuraedge_pe_feeder
  import neuraedge_tile_pkg::*;
#(
  parameter int unsigned DATA_W      = FE_DATA_W,
  parameter int unsigned ACC_W       = FE_ACC_W,
  parameter int unsigned K_W         = FE_K_W
`ifdef NEURAEDGE_FEEDER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = FE_TIMEOUT_CYC
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [K_W-1:0]    cfg_k_len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_data,
  input  logic [DATA_W-1:0] op_weight,
  output logic              pe_enable,
  output logic              mac_clear,
  output logic              accumulate_en,
  output logic [DATA_W-1:0] pe_data_in,
  output logic [DATA_W-1:0] pe_weight_in,
  output logic              pe_data_valid,
  input  logic [ACC_W-1:0]  pe_accum_out,
  input  logic              pe_accum_valid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data
`ifdef NEURAEDGE_FEEDER_TIMEOUT_EN
  ,
  output logic              res_err
`endif
);

  fe_state_t         state_q, state_d;
  logic [K_W-1:0]    k_len_q, k_len_d;
  logic [K_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0] pe_data_q, pe_data_d;
  logic [DATA_W-1:0] pe_weight_q, pe_weight_d;
  logic              pe_dv_q, pe_dv_d;
  logic              acc_en_q, acc_en_d;
  logic              res_valid_q, res_valid_d;
  logic [ACC_W-1:0]  res_data_q, res_data_d;
  logic              done_q, done_d;

`ifdef NEURAEDGE_FEEDER_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              res_err_q, res_err_d;
`endif

  // Strobes decoded directly from the registered state.
  assign busy      = (state_q != FE_IDLE);
  assign pe_enable = (state_q != FE_IDLE);
  assign mac_clear = (state_q == FE_CLEAR);
  assign op_ready  = (state_q == FE_STREAM);

  assign done          = done_q;
  assign accumulate_en = acc_en_q;
  assign pe_data_in    = pe_data_q;
  assign pe_weight_in  = pe_weight_q;
  assign pe_data_valid = pe_dv_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
`ifdef NEURAEDGE_FEEDER_TIMEOUT_EN
  assign res_err       = res_err_q;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    cnt_d       = cnt_q;
    pe_data_d   = pe_data_q;
    pe_weight_d = pe_weight_q;
    pe_dv_d     = 1'b0;
    acc_en_d    = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    done_d      = 1'b0;
`ifdef NEURAEDGE_FEEDER_TIMEOUT_EN
    wd_d        = wd_q;
    res_err_d   = res_err_q;
`endif

    case (state_q)
      FE_IDLE: begin
        if (start && (cfg_k_len != '0)) begin
          k_len_d = cfg_k_len;
          cnt_d   = '0;
          state_d = FE_CLEAR;
        end
      end
      FE_CLEAR: begin
        state_d = FE_STREAM;
      end
      FE_STREAM: begin
        if (op_valid && op_ready) begin
          pe_data_d   = op_data;
          pe_weight_d = op_weight;
          pe_dv_d     = 1'b1;
          acc_en_d    = 1'b1;
          cnt_d       = cnt_q + K_W'(1);
          if (cnt_q == (k_len_q - K_W'(1))) begin
            state_d = FE_WAIT_ACC;
`ifdef NEURAEDGE_FEEDER_TIMEOUT_EN
            wd_d    = '0;
`endif
          end
        end
      end
      FE_WAIT_ACC: begin
        if (pe_accum_valid) begin
          res_data_d  = pe_accum_out;
          res_valid_d = 1'b1;
          state_d     = FE_RESULT;
        end
`ifdef NEURAEDGE_FEEDER_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          res_data_d  = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = FE_RESULT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      FE_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = FE_IDLE;
`ifdef NEURAEDGE_FEEDER_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = FE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FE_IDLE;
      k_len_q     <= '0;
      cnt_q       <= '0;
      pe_data_q   <= '0;
      pe_weight_q <= '0;
      pe_dv_q     <= 1'b0;
      acc_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
`ifdef NEURAEDGE_FEEDER_TIMEOUT_EN
      wd_q        <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      cnt_q       <= cnt_d;
      pe_data_q   <= pe_data_d;
      pe_weight_q <= pe_weight_d;
      pe_dv_q     <= pe_dv_d;
      acc_en_q    <= acc_en_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      done_q      <= done_d;
`ifdef NEURAEDGE_FEEDER_TIMEOUT_EN
      wd_q        <= wd_d;
      res_err_q   <= res_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_neuraedge_pe_feeder.sv
// Directed, table-driven bench for neuraedge_pe_feeder; timeout case built when NEURAEDGE_FEEDER_TIMEOUT_EN is defined.
module tb_neuraedge_pe_feeder;

  logic        clk;
  logic        rst_n;
  logic [11:0] cfg_k_len;
  logic        start;
  logic        busy;
  logic        done;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  op_data;
  logic [7:0]  op_weight;
  logic        pe_enable;
  logic        mac_clear;
  logic        accumulate_en;
  logic [7:0]  pe_data_in;
  logic [7:0]  pe_weight_in;
  logic        pe_data_valid;
  logic [31:0] pe_accum_out;
  logic        pe_accum_valid;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
`ifdef NEURAEDGE_FEEDER_TIMEOUT_EN
  logic        res_err;
`endif

  int checks   = 0;
  int failures = 0;

  neuraedge_pe_feeder #(
    .DATA_W(8),
    .ACC_W(32),
    .K_W(12)
`ifdef NEURAEDGE_FEEDER_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_k_len(cfg_k_len),
    .start(start),
    .busy(busy),
    .done(done),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_data(op_data),
    .op_weight(op_weight),
    .pe_enable(pe_enable),
    .mac_clear(mac_clear),
    .accumulate_en(accumulate_en),
    .pe_data_in(pe_data_in),
    .pe_weight_in(pe_weight_in),
    .pe_data_valid(pe_data_valid),
    .pe_accum_out(pe_accum_out),
    .pe_accum_valid(pe_accum_valid),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data)
`ifdef NEURAEDGE_FEEDER_TIMEOUT_EN
    ,
    .res_err(res_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within bound");
    $fatal(1, "bench time bound expired");
  end

  typedef struct {
    logic        start;
    logic [11:0] k;
    logic        opv;
    logic [7:0]  d;
    logic [7:0]  w;
    logic        av;
    logic [31:0] acc;
    logic        rr;
    logic        busy;
    logic        opr;
    logic        clr;
    logic        en;
    logic        dv;
    logic        ae;
    logic [7:0]  pd;
    logic [7:0]  pw;
    logic        rv;
    logic [31:0] rd;
    logic        done;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    start          = 1'b0;
    cfg_k_len      = '0;
    op_valid       = 1'b0;
    op_data        = '0;
    op_weight      = '0;
    pe_accum_valid = 1'b0;
    pe_accum_out   = '0;
    res_ready      = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},      64'(busy), 64'd0);
    chk({tag, ".op_ready"},  64'(op_ready), 64'd0);
    chk({tag, ".mac_clear"}, 64'(mac_clear), 64'd0);
    chk({tag, ".pe_enable"}, 64'(pe_enable), 64'd0);
    chk({tag, ".dv"},        64'(pe_data_valid), 64'd0);
    chk({tag, ".acc_en"},    64'(accumulate_en), 64'd0);
    chk({tag, ".pe_data"},   64'(pe_data_in), 64'd0);
    chk({tag, ".pe_weight"}, 64'(pe_weight_in), 64'd0);
    chk({tag, ".res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, ".res_data"},  64'(res_data), 64'd0);
    chk({tag, ".done"},      64'(done), 64'd0);
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    chk({tag, ".busy"},      64'(busy), 64'(v.busy));
    chk({tag, ".op_ready"},  64'(op_ready), 64'(v.opr));
    chk({tag, ".mac_clear"}, 64'(mac_clear), 64'(v.clr));
    chk({tag, ".pe_enable"}, 64'(pe_enable), 64'(v.en));
    chk({tag, ".dv"},        64'(pe_data_valid), 64'(v.dv));
    chk({tag, ".acc_en"},    64'(accumulate_en), 64'(v.ae));
    chk({tag, ".pe_data"},   64'(pe_data_in), 64'(v.pd));
    chk({tag, ".pe_weight"}, 64'(pe_weight_in), 64'(v.pw));
    chk({tag, ".res_valid"}, 64'(res_valid), 64'(v.rv));
    chk({tag, ".res_data"},  64'(res_data), 64'(v.rd));
    chk({tag, ".done"},      64'(done), 64'(v.done));
  endtask

  initial begin
    int  beats;
    logic exp_dv;

    //            start k  opv d  w  av acc  rr | busy opr clr en dv ae pd pw rv rd  done
    vecs[0] = '{1'b1, 12'd4, 1'b0, 8'd0, 8'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 32'd0,   1'b0};
    vecs[1] = '{1'b0, 12'd0, 1'b0, 8'd0, 8'd0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 32'd0,   1'b0};
    vecs[2] = '{1'b0, 12'd0, 1'b1, 8'd1, 8'd2, 1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 8'd2, 1'b0, 32'd0,   1'b0};
    vecs[3] = '{1'b0, 12'd0, 1'b1, 8'd3, 8'd4, 1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 8'd4, 1'b0, 32'd0,   1'b0};
    vecs[4] = '{1'b1, 12'd9, 1'b1, 8'd5, 8'd6, 1'b1, 32'd55,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd5, 8'd6, 1'b0, 32'd0,   1'b0};
    vecs[5] = '{1'b0, 12'd0, 1'b1, 8'd7, 8'd8, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd7, 8'd8, 1'b0, 32'd0,   1'b0};
    vecs[6] = '{1'b0, 12'd0, 1'b1, 8'd9, 8'd9, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd7, 8'd8, 1'b0, 32'd0,   1'b0};
    vecs[7] = '{1'b0, 12'd0, 1'b0, 8'd0, 8'd0, 1'b1, 32'd100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd7, 8'd8, 1'b1, 32'd100, 1'b0};
    vecs[8] = '{1'b0, 12'd0, 1'b0, 8'd0, 8'd0, 1'b0, 32'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 8'd8, 1'b0, 32'd100, 1'b1};
    vecs[9] = '{1'b0, 12'd0, 1'b0, 8'd0, 8'd0, 1'b0, 32'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 8'd8, 1'b0, 32'd100, 1'b0};

    rst_n = 1'b0;
    idle_in();
    #1;
    chk_all_zero("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back k=4 dot-product, one vector per clock.
    for (int i = 0; i < 10; i++) begin
      start          = vecs[i].start;
      cfg_k_len      = vecs[i].k;
      op_valid       = vecs[i].opv;
      op_data        = vecs[i].d;
      op_weight      = vecs[i].w;
      pe_accum_valid = vecs[i].av;
      pe_accum_out   = vecs[i].acc;
      res_ready      = vecs[i].rr;
      tick();
      check_vec(i, vecs[i]);
    end
    idle_in();

    // Gapped operands, k=3, op_valid then held high past the last beat.
    start = 1'b1; cfg_k_len = 12'd3;
    tick();
    start = 1'b0; cfg_k_len = '0;
    chk("gap.clear", 64'(mac_clear), 64'd1);
    tick();
    chk("gap.stream_ready", 64'(op_ready), 64'd1);
    beats = 0;
    for (int i = 0; i < 12; i++) begin
      op_valid  = ((i % 2) == 0) || (i >= 6);
      op_data   = 8'(i + 10);
      op_weight = 8'(i);
      tick();
      exp_dv = (i == 0) || (i == 2) || (i == 4);
      chk($sformatf("gap.dv%0d", i), 64'(pe_data_valid), 64'(exp_dv));
      if (exp_dv) chk($sformatf("gap.data%0d", i), 64'(pe_data_in), 64'(i + 10));
      if (pe_data_valid) beats++;
    end
    chk("gap.beats", 64'(beats), 64'd3);
    chk("gap.ready_low", 64'(op_ready), 64'd0);
    op_valid = 1'b0;
    pe_accum_valid = 1'b1; pe_accum_out = 32'd3;
    tick();
    pe_accum_valid = 1'b0;
    chk("gap.res_data", 64'(res_data), 64'd3);
    res_ready = 1'b1;
    tick();
    chk("gap.done", 64'(done), 64'd1);
    res_ready = 1'b0;

    // Result backpressure: res_ready low for 10 cycles.
    start = 1'b1; cfg_k_len = 12'd1;
    tick();
    start = 1'b0; cfg_k_len = '0;
    tick();
    op_valid = 1'b1; op_data = 8'hAA; op_weight = 8'h55;
    tick();
    op_valid = 1'b0;
    pe_accum_valid = 1'b1; pe_accum_out = 32'hDEADBEEF;
    tick();
    pe_accum_valid = 1'b0; pe_accum_out = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold.rv%0d", i), 64'(res_valid), 64'd1);
      chk($sformatf("hold.rd%0d", i), 64'(res_data), 64'hDEADBEEF);
      chk($sformatf("hold.done%0d", i), 64'(done), 64'd0);
    end
    res_ready = 1'b1;
    tick();
    chk("hold.done_pulse", 64'(done), 64'd1);
    chk("hold.rv_drop", 64'(res_valid), 64'd0);
    tick();
    chk("hold.done_single", 64'(done), 64'd0);
    res_ready = 1'b0;

    // start with k=0 is ignored; start during STREAM does not reload k.
    start = 1'b1; cfg_k_len = 12'd0;
    tick();
    chk("k0.busy", 64'(busy), 64'd0);
    chk("k0.done", 64'(done), 64'd0);
    start = 1'b0;
    tick();
    chk("k0.busy2", 64'(busy), 64'd0);
    start = 1'b1; cfg_k_len = 12'd2;
    tick();
    start = 1'b0; cfg_k_len = '0;
    tick();
    op_valid = 1'b1; op_data = 8'h11; op_weight = 8'h22;
    start = 1'b1; cfg_k_len = 12'd7;
    tick();
    chk("restart.busy", 64'(busy), 64'd1);
    chk("restart.ready", 64'(op_ready), 64'd1);
    start = 1'b0; cfg_k_len = '0;
    op_data = 8'h33; op_weight = 8'h44;
    tick();
    chk("restart.k_kept", 64'(op_ready), 64'd0);
    chk("restart.dv_last", 64'(pe_data_valid), 64'd1);
    chk("restart.data_last", 64'(pe_data_in), 64'h33);
    tick();
    chk("restart.no_extra_beat", 64'(pe_data_valid), 64'd0);
    op_valid = 1'b0;
    pe_accum_valid = 1'b1; pe_accum_out = 32'h1234;
    tick();
    pe_accum_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    chk("restart.done", 64'(done), 64'd1);
    res_ready = 1'b0;

    // Reset mid-STREAM after 2 of 5 beats.
    start = 1'b1; cfg_k_len = 12'd5;
    tick();
    start = 1'b0; cfg_k_len = '0;
    tick();
    op_valid = 1'b1; op_data = 8'h5A; op_weight = 8'hA5;
    tick();
    tick();
    chk("rst.pre_dv", 64'(pe_data_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; cfg_k_len = 12'd1;
    tick();
    start = 1'b0; cfg_k_len = '0;
    chk("rst.clear", 64'(mac_clear), 64'd1);
    chk("rst.clear_dv", 64'(pe_data_valid), 64'd0);
    tick();
    op_valid = 1'b1; op_data = 8'h07; op_weight = 8'h09;
    tick();
    op_valid = 1'b0;
    chk("rst.one_beat_ready", 64'(op_ready), 64'd0);
    chk("rst.one_beat_data", 64'(pe_data_in), 64'h07);
    pe_accum_valid = 1'b1; pe_accum_out = 32'd63;
    tick();
    pe_accum_valid = 1'b0;
    chk("rst.res_data", 64'(res_data), 64'd63);
    res_ready = 1'b1;
    tick();
    chk("rst.done", 64'(done), 64'd1);
    res_ready = 1'b0;

`ifdef NEURAEDGE_FEEDER_TIMEOUT_EN
    // Watchdog: PE never reports, result after 16 WAIT_ACC cycles.
    start = 1'b1; cfg_k_len = 12'd1;
    tick();
    start = 1'b0; cfg_k_len = '0;
    tick();
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("wd.rv%0d", i), 64'(res_valid), 64'd0);
    end
    tick();
    chk("wd.rv", 64'(res_valid), 64'd1);
    chk("wd.err", 64'(res_err), 64'd1);
    chk("wd.rd", 64'(res_data), 64'd0);
    res_ready = 1'b1;
    tick();
    chk("wd.err_clr", 64'(res_err), 64'd0);
    chk("wd.done", 64'(done), 64'd1);
    res_ready = 1'b0;
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
